// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - fetch, regfile, writeback and execute bus of the operand stage
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;

  modport master (
    output in_valid, in_pc, in_instr, rs1_data, rs2_data,
           wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr,
           out_valid, out_pc, out_instr, out_rs1, out_rs2
  );

  modport slave (
    input  in_valid, in_pc, in_instr, rs1_data, rs2_data,
           wb_en, wb_addr, wb_data, out_ready,
    output in_ready, rs1_addr, rs2_addr,
           out_valid, out_pc, out_instr, out_rs1, out_rs2
  );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch with pending-write scoreboard and registered execute bundle
// Optional same-cycle writeback forwarding when OPERAND_FETCH_BYPASS_EN is defined.
module operand_fetch (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  operand_fetch_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic        fwd_rs1, fwd_rs2;
  logic [31:0] op1, op2;
  logic        hazard, in_ready, issue;
  logic [31:0] pending_q, pending_d;
  logic        out_valid_q;
  logic [31:0] out_pc_q, out_instr_q, out_rs1_q, out_rs2_q;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  // A writeback landing this edge is taken straight from the bus instead of waiting a cycle.
  assign fwd_rs1 = bus.wb_en && (bus.wb_addr == rs1) && (rs1 != 5'd0);
  assign fwd_rs2 = bus.wb_en && (bus.wb_addr == rs2) && (rs2 != 5'd0);
  assign op1     = fwd_rs1 ? bus.wb_data : bus.rs1_data;
  assign op2     = fwd_rs2 ? bus.wb_data : bus.rs2_data;
`else
  logic unused_wb_data;
  assign fwd_rs1        = 1'b0;
  assign fwd_rs2        = 1'b0;
  assign op1            = bus.rs1_data;
  assign op2            = bus.rs2_data;
  assign unused_wb_data = ^bus.wb_data;
`endif

  assign hazard = (uses_rs1  && (rs1 != 5'd0) && pending_q[rs1] && !fwd_rs1) ||
                  (uses_rs2  && (rs2 != 5'd0) && pending_q[rs2] && !fwd_rs2) ||
                  (writes_rd && (rd  != 5'd0) && pending_q[rd]);

  assign in_ready = !reset_i && !flush_i && !hazard && (!out_valid_q || bus.out_ready);
  assign issue    = bus.in_valid && in_ready;

  // Clear before set so an issuing writer of the same register keeps its bit.
  always_comb begin
    pending_d = pending_q;
    if (bus.wb_en && (bus.wb_addr != 5'd0)) pending_d[bus.wb_addr] = 1'b0;
    if (issue && writes_rd && (rd != 5'd0)) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
    end else if (flush_i) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (issue) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= bus.in_pc;
        out_instr_q <= bus.in_instr;
        out_rs1_q   <= op1;
        out_rs2_q   <= op2;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rs1_addr  = rs1;
  assign bus.rs2_addr  = rs2;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_rs1   = out_rs1_q;
  assign bus.out_rs2   = out_rs2_q;
endmodule
